// File: rtl/sya_pkg.sv
// Shared systolic-array package: default array dimensions and the
// row-activation element type used by the feeder and the PE bank.
package sya_pkg;

   localparam int unsigned SYA_NUM_ROW   = 16;
   localparam int unsigned SYA_ACT_WIDTH = 8;
   localparam int unsigned SYA_K_WIDTH   = 16;

   typedef logic [SYA_ACT_WIDTH-1:0] sya_act_t;

endpackage

// File: rtl/sya_act_feeder_if.sv
// Activation stream interface: upstream vector handshake plus the
// left-edge slot bus into the PE bank.
interface sya_act_feeder_if
   import sya_pkg::*;
#(
   parameter int unsigned NUM_ROW   = SYA_NUM_ROW,
   parameter int unsigned ACT_WIDTH = SYA_ACT_WIDTH
);

   logic                         in_vld;
   logic                         in_rdy;
   logic [ACT_WIDTH*NUM_ROW-1:0] in_act;
   logic                         out_rdy_left;
   logic                         out_vld_left;
   logic [ACT_WIDTH*NUM_ROW-1:0] out_act_left;
   logic                         out_acc_reset_left;
   logic                         grp_done;

   modport master (
      output in_vld, in_act, out_rdy_left,
      input  in_rdy, out_vld_left, out_act_left, out_acc_reset_left, grp_done
   );

   modport slave (
      input  in_vld, in_act, out_rdy_left,
      output in_rdy, out_vld_left, out_act_left, out_acc_reset_left, grp_done
   );

endinterface

// File: rtl/sya_skew_line.sv
// Enable-gated shift register of parameterised depth/width; one per PE row
// to skew activations against the bank's valid chain.
module sya_skew_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
         stage[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sya_act_feeder.sv
// Activation feeder: 2-entry FIFO, per-slot issue into the PE bank, row skew
// and reduction-group tracking. Build option: SYA_FEEDER_ZERO_BUBBLE_EN.
module sya_act_feeder
   import sya_pkg::*;
#(
   parameter int unsigned NUM_ROW   = SYA_NUM_ROW,
   parameter int unsigned ACT_WIDTH = SYA_ACT_WIDTH,
   parameter int unsigned K_WIDTH   = SYA_K_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [K_WIDTH-1:0] cfg_k,
   sya_act_feeder_if.slave    bus
);

   localparam int unsigned VW = ACT_WIDTH * NUM_ROW;
   localparam logic [K_WIDTH-1:0] K_ONE = 1;

   logic [VW-1:0]      fifo_mem [2];
   logic               wr_ptr, rd_ptr;
   logic [1:0]         count, count_nxt;
   logic               in_rdy_q;
   logic               push, pop, issue;

   logic [VW-1:0]      issue_vec;
   logic [VW-1:0]      act_skew;
   logic               vld_q, acc_q, grp_q;
   logic [K_WIDTH-1:0] k_cnt, k_lat, k_eff;
   logic               grp_last;

   assign issue = bus.out_rdy_left;
   assign push  = bus.in_vld & in_rdy_q;
   assign pop   = issue & (count != 2'd0);

   // A group's first vector uses the live cfg_k; later vectors use the latched length.
   always_comb begin
      count_nxt = count + {1'b0, push} - {1'b0, pop};
      k_eff     = k_lat;
      if (k_cnt == '0) k_eff = (cfg_k == '0) ? K_ONE : cfg_k;
      grp_last  = (k_cnt == k_eff - K_ONE);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.in_act;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= '0;
         in_rdy_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count    <= count_nxt;
         in_rdy_q <= (count_nxt < 2'd2);
      end
   end

   // issue_vec is the shared head of every skew line, so row r lands r+1 issues after its pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q     <= 1'b0;
         acc_q     <= 1'b0;
         grp_q     <= 1'b0;
         k_cnt     <= '0;
         k_lat     <= K_ONE;
         issue_vec <= '0;
      end else if (issue) begin
         vld_q <= pop;
         acc_q <= pop & (k_cnt == '0);
         grp_q <= pop & grp_last;
         if (pop) begin
            issue_vec <= fifo_mem[rd_ptr];
            if (k_cnt == '0) k_lat <= k_eff;
            k_cnt <= grp_last ? '0 : k_cnt + K_ONE;
         end
`ifdef SYA_FEEDER_ZERO_BUBBLE_EN
         else begin
            issue_vec <= '0;
         end
`endif
      end else begin
         grp_q <= 1'b0;
      end
   end

   for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
      sya_skew_line #(
         .DEPTH (r + 1),
         .WIDTH (ACT_WIDTH)
      ) u_line (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (issue),
         .din   (issue_vec[r*ACT_WIDTH +: ACT_WIDTH]),
         .dout  (act_skew[r*ACT_WIDTH +: ACT_WIDTH])
      );
   end

   assign bus.in_rdy             = in_rdy_q;
   assign bus.out_vld_left       = vld_q;
   assign bus.out_acc_reset_left = acc_q;
   assign bus.grp_done           = grp_q;
   assign bus.out_act_left       = act_skew;

endmodule
